// File: rtl/reflet_mem_bridge_if.sv
// reflet_mem_bridge_if: request/acknowledge memory bus between the bridge (master) and a memory slave
// Signals: mem_req/mem_we/mem_addr/mem_wdata driven by master; mem_rdata/mem_ack driven by slave.
interface reflet_mem_bridge_if #(parameter int wordsize = 16);
  logic mem_req, mem_we, mem_ack;
  logic [wordsize-1:0] mem_addr, mem_wdata, mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/reflet_mem_bridge.sv
// reflet_mem_bridge: synchronous-RAM port to request/acknowledge bus bridge with CPU step-enable
// Ports: clk, reset (async, active-high); enable (run enable); cpu_addr/cpu_data_out/cpu_write_en from
// the access unit; cpu_data_in (registered read data) and cpu_enable (one-cycle step pulse) back to it;
// mem (master side of the memory bus); bus_error (sticky timeout flag).
// Optional: define REFLET_MEM_BRIDGE_TIMEOUT_EN to abort transfers after timeout_cycles unacknowledged
// WAIT cycles; otherwise WAIT lasts until mem_ack and bus_error is tied low.
module reflet_mem_bridge #(
  parameter int wordsize = 16,
  parameter int timeout_cycles = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  input  logic                cpu_write_en,
  output logic [wordsize-1:0] cpu_data_in,
  output logic                cpu_enable,
  output logic                bus_error,
  reflet_mem_bridge_if.master mem
);
  typedef enum logic [1:0] {ISSUE = 2'd0, WAIT = 2'd1, STEP = 2'd2} state_t;
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, en_q, en_d, issue, done, timeout;
  logic [wordsize-1:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
  if (timeout_cycles < 1) begin : g_bad_timeout
    $error("timeout_cycles must be >= 1");
  end
`ifdef REFLET_MEM_BRIDGE_TIMEOUT_EN
  localparam int cw = $clog2(timeout_cycles + 1);
  logic [cw-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign timeout = state_q == WAIT && !mem.mem_ack && cnt_q == cw'(timeout_cycles - 1);
  // counter restarts on every ISSUE and saturates instead of wrapping
  always_comb begin
    cnt_d = state_q == ISSUE ? '0 : state_q == WAIT && !mem.mem_ack && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
    err_d = err_q | timeout;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign bus_error = err_q;
`else
  assign timeout = 1'b0;
  assign bus_error = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= ISSUE;
    else state_q <= state_d;
  // an acknowledge always wins over a simultaneous timeout
  always_comb
    state_d = state_q == ISSUE ? (enable ? WAIT : ISSUE)
            : state_q == WAIT ? (mem.mem_ack || timeout ? STEP : WAIT)
            : ISSUE;
  always_comb begin
    issue = state_q == ISSUE && enable;
    done = state_q == WAIT && (mem.mem_ack || timeout);
    req_d = issue | (req_q & ~done);
    we_d = issue ? cpu_write_en : we_q;
    addr_d = issue ? cpu_addr : addr_q;
    wdata_d = issue ? cpu_data_out : wdata_q;
    rd_d = done && !we_q ? (mem.mem_ack ? mem.mem_rdata : '0) : rd_q;
    en_d = state_d == STEP;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      en_q <= 1'b0;
    end else begin
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      en_q <= en_d;
    end
  assign mem.mem_req = req_q;
  assign mem.mem_we = we_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign cpu_data_in = rd_q;
  assign cpu_enable = en_q;
endmodule
